// File: rtl/acc_writeback_if.sv
// -----------------------------------------------------------------------------
// acc_writeback_if
// Write bus between the accumulator writeback stage and the unified buffer.
//
// Signals:
//   mem_we     write request (driven by master)
//   mem_addr   write address (driven by master)
//   mem_wdata  write data    (driven by master)
//   mem_ready  buffer accepts the write this cycle (driven by slave)
//
// Modports:
//   master  the writeback stage
//   slave   the unified buffer (or a bench model of it)
// -----------------------------------------------------------------------------
interface acc_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/acc_writeback.sv
// -----------------------------------------------------------------------------
// acc_writeback
// Drains accumulator product rows into the unified buffer. After a start
// command it waits for a rising edge of acc_full, snapshots both row entries,
// pulses acc_clear, then writes the two words at sequential addresses over a
// we/ready handshake. NUM_ROWS rows make one tile; done pulses at the end.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state
//   start      one-cycle tile command, only honoured in IDLE
//   base_addr  first write address, sampled with an accepted start
//   acc_full   accumulator full flag (only its rising edge captures)
//   acc_mem_0  accumulator entry, column 0
//   acc_mem_1  accumulator entry, column 1
//   acc_clear  one-cycle pulse after a snapshot
//   mem        write bus (master side): mem_we, mem_addr, mem_wdata, mem_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last word of the tile is accepted
//
// Build option:
//   RELU_EN    when defined, negative entries are stored as zero at snapshot
// -----------------------------------------------------------------------------
module acc_writeback #(
    parameter int DATA_W   = 8,
    parameter int NUM_ROWS = 2,
    parameter int ADDR_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic        [ADDR_W-1:0] base_addr,
    input  logic                     acc_full,
    input  logic signed [DATA_W-1:0] acc_mem_0,
    input  logic signed [DATA_W-1:0] acc_mem_1,
    output logic                     acc_clear,
    acc_writeback_if.master          mem,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FULL = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROWS - 1);

    state_t                    state;
    logic        [ADDR_W-1:0]  base;
    logic        [ADDR_W-1:0]  row;
    logic                      col;
    logic                      acc_full_q;
    logic signed [DATA_W-1:0]  row_buf [2];

    wire full_rise = acc_full && !acc_full_q;
    wire beat_done = mem.mem_we && mem.mem_ready;

    // Snapshot conditioning applied to each entry as it is captured.
    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Address of (row, column) within the tile; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [ADDR_W-1:0] r,
                                                    input logic              c);
        return b + (r << 1) + {{(ADDR_W-1){1'b0}}, c};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            base          <= '0;
            row           <= '0;
            col           <= 1'b0;
            acc_full_q    <= 1'b0;
            row_buf[0]    <= '0;
            row_buf[1]    <= '0;
            acc_clear     <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // The history register follows acc_full in every state, so an edge
            // that arrives while writing is absorbed rather than replayed later.
            acc_full_q <= acc_full;
            acc_clear  <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        base  <= base_addr;
                        row   <= '0;
                        col   <= 1'b0;
                        busy  <= 1'b1;
                        state <= WAIT_FULL;
                    end
                end

                WAIT_FULL: begin
                    if (full_rise) begin
                        row_buf[0]    <= relu(acc_mem_0);
                        row_buf[1]    <= relu(acc_mem_1);
                        acc_clear     <= 1'b1;
                        // First beat is presented straight from the snapshot so
                        // mem_we rises in the cycle right after the capture.
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= word_addr(base, row, 1'b0);
                        mem.mem_wdata <= relu(acc_mem_0);
                        state         <= WRITE;
                    end
                end

                WRITE: begin
                    if (beat_done) begin
                        if (!col) begin
                            col           <= 1'b1;
                            mem.mem_addr  <= word_addr(base, row, 1'b1);
                            mem.mem_wdata <= row_buf[~col];
                        end else begin
                            col        <= 1'b0;
                            mem.mem_we <= 1'b0;
                            if (row == ROW_LAST) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= WAIT_FULL;
                            end
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// -----------------------------------------------------------------------------
// tb_acc_writeback
// Directed bench for acc_writeback. A negedge monitor logs every accepted
// write and counts acc_clear / done pulses; scenario tasks compare outputs and
// the log against hand-computed values.
// -----------------------------------------------------------------------------
module tb_acc_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] base_addr;
    logic       acc_full;
    logic [7:0] acc_mem_0;
    logic [7:0] acc_mem_1;
    logic       acc_clear;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] log_addr [$];
    logic [7:0] log_data [$];
    int         clr_cnt  = 0;
    int         done_cnt = 0;

    acc_writeback_if #(.DATA_W(8), .ADDR_W(4)) mem ();

    acc_writeback #(.DATA_W(8), .NUM_ROWS(2), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .acc_full  (acc_full),
        .acc_mem_0 (acc_mem_0),
        .acc_mem_1 (acc_mem_1),
        .acc_clear (acc_clear),
        .mem       (mem.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view is what the next
    // rising edge will see.
    always @(negedge clk) begin
        if (mem.mem_we && mem.mem_ready && !reset) begin
            log_addr.push_back(mem.mem_addr);
            log_data.push_back(mem.mem_wdata);
        end
        if (acc_clear) clr_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    // Drop then raise acc_full so the DUT sees a fresh rising edge.
    task automatic edge_row(input logic [7:0] a, input logic [7:0] b);
        acc_full = 1'b0;
        tick();
        acc_mem_0 = a;
        acc_mem_1 = b;
        acc_full  = 1'b1;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = 4'h0; acc_full = 1'b0;
        acc_mem_0 = 8'h00; acc_mem_1 = 8'h00; mem.mem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        vectors++; if (mem.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", mem.mem_we); end
        vectors++; if (mem.mem_addr !== 4'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", mem.mem_addr); end
        vectors++; if (mem.mem_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_wdata got %h want 00", mem.mem_wdata); end
        vectors++; if (acc_clear !== 1'b0) begin miscompares++; $display("FAIL reset_clear got %b want 0", acc_clear); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_basic_drain();
        int mark, clr0, done0;
        logic [3:0] ea [4];
        logic [7:0] ed [4];
        ea = '{4'h2, 4'h3, 4'h4, 4'h5};
        ed = '{8'h05, 8'h0B, 8'h11, 8'h1D};
        apply_reset();
        mem.mem_ready = 1'b1;
        mark = log_addr.size(); clr0 = clr_cnt; done0 = done_cnt;
        do_start(4'h2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
        edge_row(8'h05, 8'h0B);
        vectors++; if (acc_clear !== 1'b1) begin miscompares++; $display("FAIL basic_clear got %b want 1", acc_clear); end
        vectors++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 4'h2 || mem.mem_wdata !== 8'h05) begin
            miscompares++; $display("FAIL basic_beat0 got we=%b a=%h d=%h want 1 2 05", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
        tick();
        vectors++; if (acc_clear !== 1'b0) begin miscompares++; $display("FAIL basic_clear_drop got %b want 0", acc_clear); end
        tick();
        vectors++; if (mem.mem_we !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_row_gap got we=%b busy=%b want 0 1", mem.mem_we, busy); end
        edge_row(8'h11, 8'h1D);
        tick(); tick();
        vectors++; if (done !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_done got done=%b busy=%b want 1 1", done, busy); end
        tick();
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_idle got done=%b busy=%b want 0 0", done, busy); end
        vectors++; if (log_addr.size() - mark !== 4) begin
            miscompares++; $display("FAIL basic_nwrites got %0d want 4", log_addr.size() - mark); end
        for (int i = 0; i < 4; i++) begin
            if (mark + i < log_addr.size()) begin
                vectors++; if (log_addr[mark+i] !== ea[i] || log_data[mark+i] !== ed[i]) begin
                    miscompares++; $display("FAIL basic_write%0d got (%h,%h) want (%h,%h)", i, log_addr[mark+i], log_data[mark+i], ea[i], ed[i]); end
            end
        end
        vectors++; if (clr_cnt - clr0 !== 2) begin miscompares++; $display("FAIL basic_nclear got %0d want 2", clr_cnt - clr0); end
        vectors++; if (done_cnt - done0 !== 1) begin miscompares++; $display("FAIL basic_ndone got %0d want 1", done_cnt - done0); end
    endtask

    task automatic test_backpressure();
        int mark;
        apply_reset();
        mem.mem_ready = 1'b0;
        mark = log_addr.size();
        do_start(4'h0);
        edge_row(8'h5A, 8'h6B);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 4'h0 || mem.mem_wdata !== 8'h5A) begin
                miscompares++; $display("FAIL bp_hold%0d got we=%b a=%h d=%h want 1 0 5A", i, mem.mem_we, mem.mem_addr, mem.mem_wdata); end
            tick();
        end
        mem.mem_ready = 1'b1;
        tick();
        vectors++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 4'h1 || mem.mem_wdata !== 8'h6B) begin
            miscompares++; $display("FAIL bp_beat1 got we=%b a=%h d=%h want 1 1 6B", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
        tick();
        vectors++; if (mem.mem_we !== 1'b0) begin miscompares++; $display("FAIL bp_we_drop got %b want 0", mem.mem_we); end
        vectors++; if (log_addr.size() - mark !== 2) begin
            miscompares++; $display("FAIL bp_nwrites got %0d want 2", log_addr.size() - mark); end
        else begin
            vectors++; if (log_addr[mark] !== 4'h0 || log_data[mark] !== 8'h5A || log_addr[mark+1] !== 4'h1 || log_data[mark+1] !== 8'h6B) begin
                miscompares++; $display("FAIL bp_writes got (%h,%h)(%h,%h) want (0,5A)(1,6B)", log_addr[mark], log_data[mark], log_addr[mark+1], log_data[mark+1]); end
        end
    endtask

    task automatic test_level_vs_edge();
        acc_full = 1'b1;
        apply_reset();
        mem.mem_ready = 1'b1;
        do_start(4'h0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mem.mem_we !== 1'b0 || acc_clear !== 1'b0) begin
                miscompares++; $display("FAIL level_nocap%0d got we=%b clr=%b want 0 0", i, mem.mem_we, acc_clear); end
            tick();
        end
        edge_row(8'h01, 8'h02);
        vectors++; if (mem.mem_we !== 1'b1 || acc_clear !== 1'b1 || mem.mem_wdata !== 8'h01) begin
            miscompares++; $display("FAIL level_cap got we=%b clr=%b d=%h want 1 1 01", mem.mem_we, acc_clear, mem.mem_wdata); end
    endtask

    task automatic test_wrap_and_busy_start();
        int mark;
        logic [3:0] ea [4];
        logic [7:0] ed [4];
        ea = '{4'hF, 4'h0, 4'h1, 4'h2};
        ed = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        acc_full = 1'b0;
        apply_reset();
        mem.mem_ready = 1'b1;
        mark = log_addr.size();
        do_start(4'hF);
        edge_row(8'hA1, 8'hA2);
        start = 1'b1; base_addr = 4'h7;
        tick();
        start = 1'b0;
        tick();
        do_start(4'h7);
        edge_row(8'hA3, 8'hA4);
        tick(); tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b want 1", done); end
        vectors++; if (log_addr.size() - mark !== 4) begin
            miscompares++; $display("FAIL wrap_nwrites got %0d want 4", log_addr.size() - mark); end
        for (int i = 0; i < 4; i++) begin
            if (mark + i < log_addr.size()) begin
                vectors++; if (log_addr[mark+i] !== ea[i] || log_data[mark+i] !== ed[i]) begin
                    miscompares++; $display("FAIL wrap_write%0d got (%h,%h) want (%h,%h)", i, log_addr[mark+i], log_data[mark+i], ea[i], ed[i]); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int mark;
        logic [3:0] ea [4];
        logic [7:0] ed [4];
        ea = '{4'h8, 4'h9, 4'hA, 4'hB};
        ed = '{8'h21, 8'h22, 8'h23, 8'h24};
        apply_reset();
        mem.mem_ready = 1'b0;
        do_start(4'h0);
        edge_row(8'h33, 8'h44);
        vectors++; if (mem.mem_we !== 1'b1) begin miscompares++; $display("FAIL rmw_pre_we got %b want 1", mem.mem_we); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (mem.mem_we !== 1'b0 || mem.mem_addr !== 4'h0 || mem.mem_wdata !== 8'h00 ||
                       acc_clear !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL rmw_outputs got we=%b a=%h d=%h clr=%b busy=%b done=%b want all 0",
                                    mem.mem_we, mem.mem_addr, mem.mem_wdata, acc_clear, busy, done); end
        mem.mem_ready = 1'b1;
        mark = log_addr.size();
        do_start(4'h8);
        edge_row(8'h21, 8'h22);
        tick(); tick();
        edge_row(8'h23, 8'h24);
        tick(); tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rmw_done got %b want 1", done); end
        vectors++; if (log_addr.size() - mark !== 4) begin
            miscompares++; $display("FAIL rmw_nwrites got %0d want 4", log_addr.size() - mark); end
        for (int i = 0; i < 4; i++) begin
            if (mark + i < log_addr.size()) begin
                vectors++; if (log_addr[mark+i] !== ea[i] || log_data[mark+i] !== ed[i]) begin
                    miscompares++; $display("FAIL rmw_write%0d got (%h,%h) want (%h,%h)", i, log_addr[mark+i], log_data[mark+i], ea[i], ed[i]); end
            end
        end
        tick();
    endtask

    task automatic test_relu();
        logic [7:0] e0, e2;
`ifdef RELU_EN
        e0 = 8'h00; e2 = 8'h00;
`else
        e0 = 8'hF3; e2 = 8'h80;
`endif
        apply_reset();
        mem.mem_ready = 1'b1;
        do_start(4'h4);
        edge_row(8'hF3, 8'h07);
        vectors++; if (mem.mem_wdata !== e0) begin miscompares++; $display("FAIL relu_neg got %h want %h", mem.mem_wdata, e0); end
        tick();
        vectors++; if (mem.mem_wdata !== 8'h07) begin miscompares++; $display("FAIL relu_pos got %h want 07", mem.mem_wdata); end
        tick();
        edge_row(8'h80, 8'h7F);
        vectors++; if (mem.mem_wdata !== e2 || mem.mem_addr !== 4'h6) begin
            miscompares++; $display("FAIL relu_min got a=%h d=%h want 6 %h", mem.mem_addr, mem.mem_wdata, e2); end
        tick();
        vectors++; if (mem.mem_wdata !== 8'h7F) begin miscompares++; $display("FAIL relu_max got %h want 7F", mem.mem_wdata); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL relu_done got %b want 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_level_vs_edge();
        test_wrap_and_busy_start();
        test_reset_mid_write();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
